// File: rtl/dcache_tag_ctrl.sv
// dcache_tag_ctrl: arbitration and sequencing for the single-port data-cache
// tag SRAM. Runs a clearing sweep after reset, serves flushes as full sweeps,
// and otherwise shares the port between tag updates and lookups.
module dcache_tag_ctrl #(
    parameter int SET_W   = 4,
    parameter int TAG_W   = 22,
    parameter int ENTRY_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lkp_valid,
    output logic               lkp_ready,
    input  logic [SET_W-1:0]   lkp_set,
    input  logic [TAG_W-1:0]   lkp_tag,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic               rsp_dirty,
    output logic [TAG_W-1:0]   rsp_tag,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [SET_W-1:0]   upd_set,
    input  logic [ENTRY_W-1:0] upd_entry,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               busy,
    output logic               tag_csb,
    output logic               tag_web,
    output logic [SET_W-1:0]   tag_addr,
    output logic [ENTRY_W-1:0] tag_din,
    input  logic [ENTRY_W-1:0] tag_dout
);

    typedef enum logic [1:0] {
        INIT_SWEEP  = 2'd0,
        RUN         = 2'd1,
        FLUSH_SWEEP = 2'd2
    } state_t;

    state_t             r_state;
    logic [SET_W-1:0]   r_cnt;
    logic               r_flush_pending;
    logic               r_rsp_valid;
    logic               r_flush_done;
    logic [TAG_W-1:0]   r_cap_tag;

    logic               w_sweep;
    logic               w_upd_fire;
    logic               w_lkp_fire;
    logic               w_cnt_last;
    logic               w_flush_any;

    // Handshake decode; readies depend only on state and upd_valid
    always_comb begin
        w_sweep     = (r_state != RUN);
        upd_ready   = (r_state == RUN) && !r_flush_pending;
        lkp_ready   = upd_ready && !upd_valid;
        w_upd_fire  = upd_valid && upd_ready;
        w_lkp_fire  = lkp_valid && lkp_ready;
        w_cnt_last  = (r_cnt == '1);
        w_flush_any = r_flush_pending || flush_req;
    end

    // SRAM port drive: sweep write, else update write, else lookup read, else idle
    always_comb begin
        busy     = w_sweep;
        tag_csb  = 1'b1;
        tag_web  = 1'b1;
        tag_addr = '0;
        tag_din  = '0;
        if (w_sweep) begin
            tag_csb  = 1'b0;
            tag_web  = 1'b0;
            tag_addr = r_cnt;
        end else if (w_upd_fire) begin
            tag_csb  = 1'b0;
            tag_web  = 1'b0;
            tag_addr = upd_set;
            tag_din  = upd_entry;
        end else if (w_lkp_fire) begin
            tag_csb  = 1'b0;
            tag_addr = lkp_set;
        end
    end

    // Lookup response built from the SRAM read data and the captured tag
    always_comb begin
        rsp_valid  = r_rsp_valid;
        flush_done = r_flush_done;
        rsp_hit    = tag_dout[ENTRY_W-1] && (tag_dout[TAG_W-1:0] == r_cap_tag);
        rsp_dirty  = tag_dout[ENTRY_W-2];
        rsp_tag    = tag_dout[TAG_W-1:0];
    end

    // Sequencer: sweeps, flush bookkeeping and registered response strobes.
    // A request arriving on the edge that enters a flush sweep is served by
    // that sweep, since every set is cleared after the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= INIT_SWEEP;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_flush_done    <= 1'b0;
            r_cap_tag       <= '0;
        end else begin
            r_rsp_valid  <= w_lkp_fire;
            r_flush_done <= 1'b0;
            if (w_lkp_fire) begin
                r_cap_tag <= lkp_tag;
            end
            case (r_state)
                INIT_SWEEP, FLUSH_SWEEP: begin
                    r_cnt           <= r_cnt + 1'b1;
                    r_flush_pending <= w_flush_any;
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (r_state == FLUSH_SWEEP) begin
                            r_flush_done <= 1'b1;
                        end
                        if (w_flush_any) begin
                            r_state         <= FLUSH_SWEEP;
                            r_flush_pending <= 1'b0;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_flush_any) begin
                        r_state         <= FLUSH_SWEEP;
                        r_cnt           <= '0;
                        r_flush_pending <= 1'b0;
                    end
                end
                default: begin
                    r_state <= INIT_SWEEP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// tb_dcache_tag_ctrl: directed test of the tag SRAM sequencer against a
// behavioural single-port SRAM with registered read address.
module tb_dcache_tag_ctrl;

    localparam int SET_W   = 4;
    localparam int TAG_W   = 22;
    localparam int ENTRY_W = 24;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               lkp_valid = 1'b0;
    logic               lkp_ready;
    logic [SET_W-1:0]   lkp_set = '0;
    logic [TAG_W-1:0]   lkp_tag = '0;
    logic               rsp_valid;
    logic               rsp_hit;
    logic               rsp_dirty;
    logic [TAG_W-1:0]   rsp_tag;
    logic               upd_valid = 1'b0;
    logic               upd_ready;
    logic [SET_W-1:0]   upd_set = '0;
    logic [ENTRY_W-1:0] upd_entry = '0;
    logic               flush_req = 1'b0;
    logic               flush_done;
    logic               busy;
    logic               tag_csb;
    logic               tag_web;
    logic [SET_W-1:0]   tag_addr;
    logic [ENTRY_W-1:0] tag_din;
    logic [ENTRY_W-1:0] tag_dout;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    dcache_tag_ctrl #(
        .SET_W   (SET_W),
        .TAG_W   (TAG_W),
        .ENTRY_W (ENTRY_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lkp_valid  (lkp_valid),
        .lkp_ready  (lkp_ready),
        .lkp_set    (lkp_set),
        .lkp_tag    (lkp_tag),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_dirty  (rsp_dirty),
        .rsp_tag    (rsp_tag),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_set    (upd_set),
        .upd_entry  (upd_entry),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .busy       (busy),
        .tag_csb    (tag_csb),
        .tag_web    (tag_web),
        .tag_addr   (tag_addr),
        .tag_din    (tag_din),
        .tag_dout   (tag_dout)
    );

    // Behavioural tag SRAM: write on selected write cycles, read data follows
    // the address registered on any selected cycle
    logic [ENTRY_W-1:0] mem [16];
    logic [SET_W-1:0]   mem_raddr = '0;
    initial for (int i = 0; i < 16; i++) mem[i] = 24'hFFFFFF;
    always @(posedge clk) begin
        if (!tag_csb) begin
            if (!tag_web) mem[tag_addr] <= tag_din;
            mem_raddr <= tag_addr;
        end
    end
    assign tag_dout = mem[mem_raddr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks 16 sweep cycles starting at the current point; optionally pulses
    // flush_req during one of them
    task automatic sweep_check(input string tag, input int inject_at);
        for (int i = 0; i < 16; i++) begin
            flush_req = (i == inject_at);
            #1;
            check(tag, {59'd0, tag_csb, tag_web, busy, lkp_ready, upd_ready, tag_addr, tag_din},
                  {59'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(i), 24'd0});
            tick();
        end
        flush_req = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        check("reset_ctrl", {rsp_valid, flush_done, lkp_ready, upd_ready, busy}, 5'b00001);
        check("reset_sram", {tag_csb, tag_web, tag_addr, tag_din}, '0);

        // Init sweep
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check("init_sweep", -1);
        #1;
        check("init_ready", {lkp_ready, upd_ready, busy, flush_done}, 4'b1100);

        // Lookup set 5 after clearing: miss
        lkp_valid = 1'b1; lkp_set = 4'd5; lkp_tag = 22'd0;
        #1;
        check("lkp5_drive", {tag_csb, tag_web, tag_addr}, {1'b0, 1'b1, 4'd5});
        tick();
        lkp_valid = 1'b0;
        #1;
        check("lkp5_rsp", {rsp_valid, rsp_hit}, 2'b10);
        tick();
        check("lkp5_rsp_gone", rsp_valid, 1'b0);

        // Update set 3 then look it up, hit and miss
        upd_valid = 1'b1; upd_set = 4'd3; upd_entry = {1'b1, 1'b0, 22'h12345};
        #1;
        check("upd3_ready", {upd_ready, lkp_ready}, 2'b10);
        check("upd3_drive", {tag_csb, tag_web, tag_addr, tag_din}, {1'b0, 1'b0, 4'd3, 24'h812345});
        tick();
        upd_valid = 1'b0;
        lkp_valid = 1'b1; lkp_set = 4'd3; lkp_tag = 22'h12345;
        tick();
        lkp_tag = 22'h12346;
        #1;
        check("lkp3_hit", {rsp_valid, rsp_hit, rsp_dirty}, 3'b110);
        tick();
        lkp_valid = 1'b0;
        #1;
        check("lkp3_miss", {rsp_valid, rsp_hit}, 2'b10);
        check("lkp3_victim", rsp_tag, 22'h12345);
        tick();

        // Simultaneous update and lookup: update wins, lookup follows
        upd_valid = 1'b1; upd_set = 4'd7; upd_entry = {1'b1, 1'b1, 22'h00ABC};
        lkp_valid = 1'b1; lkp_set = 4'd7; lkp_tag = 22'h00ABC;
        #1;
        check("arb_ready", {upd_ready, lkp_ready, tag_web}, 3'b100);
        tick();
        upd_valid = 1'b0;
        #1;
        check("arb_lkp_next", {lkp_ready, rsp_valid, tag_web, tag_addr}, {1'b1, 1'b0, 1'b1, 4'd7});
        tick();
        lkp_valid = 1'b0;
        #1;
        check("arb_rsp", {rsp_valid, rsp_hit, rsp_dirty}, 3'b111);
        tick();

        // Fill every set valid+dirty, then flush
        for (int i = 0; i < 16; i++) begin
            upd_valid = 1'b1; upd_set = 4'(i); upd_entry = {2'b11, 22'(i + 'h100)};
            tick();
        end
        upd_valid = 1'b0;
        lkp_valid = 1'b1; lkp_set = 4'd9; lkp_tag = 22'h109;
        tick();
        lkp_valid = 1'b0;
        #1;
        check("fill_hit9", {rsp_valid, rsp_hit, rsp_dirty}, 3'b111);
        flush_req = 1'b1;
        #1;
        check("flush_req_ready", {upd_ready, tag_csb, busy}, 3'b110);
        tick();
        sweep_check("flush_sweep", -1);
        #1;
        check("flush_done_1", {flush_done, upd_ready, busy}, 3'b110);
        tick();
        check("flush_done_clr", flush_done, 1'b0);
        for (int i = 0; i < 16; i++) begin
            lkp_valid = 1'b1; lkp_set = 4'(i); lkp_tag = 22'(i + 'h100);
            tick();
            #1;
            check("post_flush_miss", {rsp_valid, rsp_hit}, 2'b10);
        end
        lkp_valid = 1'b0;
        tick();

        // Flush requested during the eighth cycle of a flush sweep
        flush_req = 1'b1;
        tick();
        sweep_check("flush2_a", 7);
        #1;
        check("flush2_done_a", {flush_done, busy, upd_ready}, 3'b110);
        sweep_check("flush2_b", -1);
        #1;
        check("flush2_done_b", {flush_done, busy, upd_ready}, 3'b101);
        tick();
        check("flush2_idle", {flush_done, busy}, 2'b00);

        // Reset during a lookup stream
        for (int i = 0; i < 3; i++) begin
            lkp_valid = 1'b1; lkp_set = 4'(i); lkp_tag = 22'd0;
            tick();
        end
        #1;
        check("stream_rsp", rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_reset", {rsp_valid, lkp_ready, busy, tag_csb, tag_addr}, {3'b001, 1'b0, 4'd0});
        tick();
        rst_n = 1'b1;
        sweep_check("reinit_sweep", -1);
        #1;
        check("reinit_ready", {lkp_ready, flush_done, rsp_valid}, 3'b100);
        tick();
        lkp_valid = 1'b0;
        #1;
        check("reinit_rsp", {rsp_valid, rsp_hit}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
